oka_mul_seq: RTL and testbench
==============================

Name: oka_mul_seq

Overview:
- Parametrised, iterative successor to the fixed-width combinational overlap-free Karatsuba (OKA) GF(2)[x] multipliers.
- Splits each N-bit operand into even- and odd-indexed halves. Computes the three half-products Pe, Po and Pm serially on one shared H-by-D digit-serial carry-less multiplier, then recombines them without overlap.
- Sits in the binary-field (e.g. GF(2^163)) datapath ahead of modular reduction.
- Uses valid/ready handshakes on both sides.

Parameters:
- N, 163: operand width in bits; N >= 2.
- D, 8: digit width consumed per cycle; 1 <= D <= H.
- H is derived as (N+1)/2 (integer division): half-operand width.
- K is derived as ceil(H/D): cycles per half-product.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a  in  N  multiplicand, polynomial over GF(2), bit i = coefficient of x^i.
- b  in  N  multiplier, same encoding.
- in_valid  in  1  a/b valid.
- in_ready  out  1  block can accept an operand pair.
- y  out  2N-1  carry-less product a*b, unreduced.
- out_valid  out  1  y valid.
- out_ready  in  1  consumer accepts y.

Behaviour:
- Reset values (async on rst_n low, held while low): state=IDLE; in_ready=0 during reset, then 1 in IDLE; out_valid=0; y=0; operand, digit-counter and accumulator registers all 0.
- Split rules:
  - ae[k]=a[2k]; ao[k]=a[2k+1], with ao[H-1]=0 when N is odd. Same rules for b.
  - am=ae^ao; bm=be^bo.
- Products: Pe=ae*be, Po=ao*bo, Pm=am*bm. Each is 2H-1 bits, carry-less.
- States: IDLE -> MUL_E -> MUL_O -> MUL_M -> COMB -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register a and b, clear accumulator and digit counter i, go to MUL_E.
  - a and b are ignored after capture.
- MUL_x (K cycles each):
  - Each cycle: acc ^= (x_a * digit_i(x_b)) << (D*i); i++.
  - Digits are taken LSB first; the last digit is zero-padded when D does not divide H.
  - At i=K-1: store acc into Pe, Po or Pm respectively, clear acc and i, advance state.
- COMB (1 cycle):
  - Pc = Pm^Pe^Po.
  - y[2k] = Pe[k] ^ Po[k-1], with Po[-1]=0.
  - y[2k+1] = Pc[k].
  - Bits at index >= 2N-1 are discarded; they are provably 0 for odd N.
  - Register y, go to DONE.
- DONE:
  - out_valid=1; y stable until out_valid&out_ready.
  - On handshake: out_valid=0, go to IDLE. in_ready rises on the following cycle; there is no same-cycle re-accept.
- Latency: accept edge t0 -> out_valid high from edge t0+3K+1. N=163, D=8 gives K=11, latency 34 cycles.
- Throughput: one product per 3K+3 cycles minimum.
- in_ready=0 in every state except IDLE. in_valid is ignored outside IDLE.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation: immediately aborts to IDLE. Partial results are lost and there are no spurious out_valid pulses.
- Zero operands are legal: the product is 0 with the same latency.

Decomposition:
- Shared package oka_pkg holds:
  - state enum (IDLE, MUL_E, MUL_O, MUL_M, COMB, DONE);
  - function clog2;
  - function ceil_div;
  - localparam helpers for H and K.
- One sub-module, gf2_digit_mul: combinational H-by-D carry-less multiply, output H+D-1 bits, parametrised by H and D.
- Top level holds the FSM, counter, accumulator, Pe/Po/Pm registers and the recombination logic.

Test Plan:
- Reset: hold rst_n=0 then release -> out_valid=0, y=0, in_ready=1 one cycle after release. Assert rst_n=0 mid MUL_O -> state IDLE asynchronously, no out_valid.
- N=4, D=2 (H=2, K=1): a=4'hF, b=4'hF -> y=7'h55 with out_valid 4 cycles after accept. a=4'h3, b=4'h5 -> y=7'h0F.
- N=163, D=8: a=1, b=1 -> y=1 at 34 cycles. a=b=x^162 -> only y[324]=1. a=x^161, b=x^1 -> only y[162]=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> y and out_valid held, in_ready=0, new in_valid ignored. Then out_ready=1 for one cycle -> in_ready=1 the next cycle.
- Odd/non-dividing config N=5, D=2 (H=3, K=2): a=5'h1F, b=5'h1F -> y=9'h155.
- Random: 1000 random pairs each for (N=163, D=8), (N=5, D=2) and (N=16, D=3), with random in_valid/out_ready gaps -> y matches a software carry-less multiply model on every handshake.

Source files
------------

// File: rtl/oka_pkg.sv
// Shared definitions for the sequential overlap-free Karatsuba GF(2)[x]
// multiplier: FSM state encoding and the elaboration-time helpers that
// derive the half-operand width H and the per-half-product cycle count K.
package oka_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL_E,
        MUL_O,
        MUL_M,
        COMB,
        DONE
    } state_t;

    // ceil(log2(v)); clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Half-operand width: even/odd split of an n-bit operand.
    function automatic int half_w(input int n);
        return (n + 1) / 2;
    endfunction

    // Cycles needed to run one H-bit half-product through a D-bit digit.
    function automatic int digit_cycles(input int n, input int d);
        return ceil_div(half_w(n), d);
    endfunction

endpackage

// File: rtl/gf2_digit_mul.sv
// Combinational carry-less (GF(2)[x]) multiply of an H-bit operand by a
// D-bit digit.
//   a : H-bit operand
//   b : D-bit digit
//   p : H+D-1 bit carry-less product
module gf2_digit_mul #(
    parameter int H = 82,
    parameter int D = 8
) (
    input  logic [H-1:0]   a,
    input  logic [D-1:0]   b,
    output logic [H+D-2:0] p
);

    always_comb begin
        p = '0;
        for (int j = 0; j < D; j++) begin
            if (b[j]) p = p ^ ((H+D-1)'(a) << j);
        end
    end

endmodule

// File: rtl/oka_mul_seq.sv
// Iterative overlap-free Karatsuba multiplier over GF(2)[x].
// Operands are split into even/odd-indexed halves; the three half-products
// Pe, Po, Pm are computed one after another on a shared H-by-D digit-serial
// multiplier and recombined by bit interleaving (no overlapping adds).
//   clk, rst_n          : clock, async active-low reset
//   a, b, in_valid      : operand pair, accepted when in_ready is high
//   in_ready            : high only in IDLE
//   y, out_valid        : unreduced 2N-1 bit product, held until out_ready
//   out_ready           : consumer accept
module oka_mul_seq
    import oka_pkg::*;
#(
    parameter int N = 163,
    parameter int D = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*N-2:0] y,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int H  = half_w(N);
    localparam int K  = digit_cycles(N, D);
    localparam int PW = 2*H - 1;           // half-product width
    localparam int MW = H + D - 1;         // digit-multiplier output width
    localparam int CW = (K > 1) ? clog2(K) : 1;
    localparam int YW = 2*N - 1;
    localparam int FW = 4*H - 1;           // interleaved width before trimming
    localparam logic [CW-1:0] I_LAST = CW'(K - 1);

    state_t          state;
    logic [N-1:0]    a_q, b_q;
    logic [CW-1:0]   i_q;
    logic [PW-1:0]   acc, pe, po, pm;

    // Odd N: the top odd half-bit falls off the operand and reads as 0.
    logic [2*H-1:0]  a_ext, b_ext;
    logic [H-1:0]    ae, ao, be, bo, op_a, op_b;
    logic [K*D-1:0]  op_b_pad;
    logic [D-1:0]    digit;
    logic [MW-1:0]   prod;
    logic [PW-1:0]   prod_x, part, acc_nxt;
    int              sh;

    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[N-1:0] = a_q;
        b_ext[N-1:0] = b_q;
        ae = '0; ao = '0; be = '0; bo = '0;
        for (int k = 0; k < H; k++) begin
            ae[k] = a_ext[2*k];
            ao[k] = a_ext[2*k+1];
            be[k] = b_ext[2*k];
            bo[k] = b_ext[2*k+1];
        end
    end

    always_comb begin
        op_a = ae;
        op_b = be;
        case (state)
            MUL_O: begin op_a = ao;      op_b = bo;      end
            MUL_M: begin op_a = ae ^ ao; op_b = be ^ bo; end
            default: ;
        endcase
    end

    // Digits LSB first; the last digit is zero-padded when D does not divide H.
    always_comb begin
        op_b_pad = '0;
        op_b_pad[H-1:0] = op_b;
        sh = D * int'(i_q);
        digit = op_b_pad[sh +: D];
    end

    gf2_digit_mul #(.H(H), .D(D)) u_dmul (
        .a (op_a),
        .b (digit),
        .p (prod)
    );

    // MW <= PW since D <= H; bits shifted past PW are provably zero.
    always_comb begin
        prod_x = '0;
        prod_x[MW-1:0] = prod;
        part    = prod_x << sh;
        acc_nxt = acc ^ part;
    end

    // Recombination: y(x) = Pe(x^2) + x^2*Po(x^2) + x*Pc(x^2).
    logic [PW-1:0]   pc;
    logic [PW:0]     pe_x, po_sh;
    logic [FW-1:0]   y_full;

    always_comb begin
        pc     = pm ^ pe ^ po;
        pe_x   = {1'b0, pe};
        po_sh  = {po, 1'b0};
        y_full = '0;
        for (int k = 0; k < 2*H; k++) y_full[2*k]   = pe_x[k] ^ po_sh[k];
        for (int k = 0; k < PW; k++)  y_full[2*k+1] = pc[k];
    end

    // Odd N: the top interleaved bits are always zero and are dropped.
    generate
        if (FW > YW) begin : g_trim
            logic unused_top;
            assign unused_top = ^y_full[FW-1:YW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            a_q       <= '0;
            b_q       <= '0;
            i_q       <= '0;
            acc       <= '0;
            pe        <= '0;
            po        <= '0;
            pm        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= '0;
                        i_q      <= '0;
                        in_ready <= 1'b0;
                        state    <= MUL_E;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                MUL_E, MUL_O, MUL_M: begin
                    if (i_q == I_LAST) begin
                        acc <= '0;
                        i_q <= '0;
                        if (state == MUL_E) begin
                            pe    <= acc_nxt;
                            state <= MUL_O;
                        end else if (state == MUL_O) begin
                            po    <= acc_nxt;
                            state <= MUL_M;
                        end else begin
                            pm    <= acc_nxt;
                            state <= COMB;
                        end
                    end else begin
                        acc <= acc_nxt;
                        i_q <= i_q + CW'(1);
                    end
                end
                COMB: begin
                    y         <= y_full[YW-1:0];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oka_mul_seq.sv
// Bench for oka_mul_seq: four instances (N/D = 163/8, 4/2, 5/2, 16/3)
// share one clock and reset; directed table, corner sequences, random pairs.
module tb_oka_mul_seq;

    logic              clk;
    logic              rst_n;
    logic [3:0]        iv, ordy;
    wire  [3:0]        irdy, ov;
    logic [3:0][162:0] av, bv;
    logic [324:0]      y0;
    logic [6:0]        y1;
    logic [8:0]        y2;
    logic [30:0]       y3;
    wire  [324:0]      ys [4];

    assign ys[0] = y0;
    assign ys[1] = {318'b0, y1};
    assign ys[2] = {316'b0, y2};
    assign ys[3] = {294'b0, y3};

    int checks;
    int fails;

    oka_mul_seq #(.N(163), .D(8)) u0 (
        .clk(clk), .rst_n(rst_n), .a(av[0]), .b(bv[0]), .in_valid(iv[0]),
        .in_ready(irdy[0]), .y(y0), .out_valid(ov[0]), .out_ready(ordy[0]));
    oka_mul_seq #(.N(4), .D(2)) u1 (
        .clk(clk), .rst_n(rst_n), .a(av[1][3:0]), .b(bv[1][3:0]), .in_valid(iv[1]),
        .in_ready(irdy[1]), .y(y1), .out_valid(ov[1]), .out_ready(ordy[1]));
    oka_mul_seq #(.N(5), .D(2)) u2 (
        .clk(clk), .rst_n(rst_n), .a(av[2][4:0]), .b(bv[2][4:0]), .in_valid(iv[2]),
        .in_ready(irdy[2]), .y(y2), .out_valid(ov[2]), .out_ready(ordy[2]));
    oka_mul_seq #(.N(16), .D(3)) u3 (
        .clk(clk), .rst_n(rst_n), .a(av[3][15:0]), .b(bv[3][15:0]), .in_valid(iv[3]),
        .in_ready(irdy[3]), .y(y3), .out_valid(ov[3]), .out_ready(ordy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nw(input int c);
        case (c)
            0: return 163;
            1: return 4;
            2: return 5;
            default: return 16;
        endcase
    endfunction

    // Expected accept-to-out_valid latency, 3K+1 with K = ceil(ceil(N/2)/D).
    function automatic int exp_lat(input int c);
        case (c)
            0: return 34;
            1: return 4;
            2: return 7;
            default: return 10;
        endcase
    endfunction

    function automatic logic [324:0] clmul(input logic [162:0] x, input logic [162:0] z);
        logic [324:0] r;
        r = '0;
        for (int i = 0; i < 163; i++) if (z[i]) r = r ^ (325'(x) << i);
        return r;
    endfunction

    function automatic logic [162:0] rnd(input int c);
        logic [191:0] w;
        logic [162:0] m;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        m = (163'(1) << nw(c)) - 163'(1);
        return w[162:0] & m;
    endfunction

    task automatic chk(input string nm, input logic [324:0] act, input logic [324:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // One full transaction on instance c; returns y and latency (-1 on timeout).
    task automatic xact(input int c, input logic [162:0] a_in, input logic [162:0] b_in,
                        input int pre_gap, input int post_gap,
                        output logic [324:0] yv, output int lat);
        int n;
        repeat (pre_gap) @(negedge clk);
        av[c] = a_in;
        bv[c] = b_in;
        iv[c] = 1'b1;
        n = 0;
        while (!irdy[c] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!irdy[c]) begin
            chk("in_ready_timeout", 325'(irdy[c]), 325'(1));
            iv[c] = 1'b0;
            yv = '0;
            lat = -1;
            return;
        end
        @(posedge clk);
        #1;
        iv[c] = 1'b0;
        av[c] = ~a_in;  // operands must be ignored after capture
        bv[c] = ~b_in;
        lat = 0;
        while (!ov[c] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!ov[c]) begin
            chk("out_valid_timeout", 325'(ov[c]), 325'(1));
            yv = '0;
            lat = -1;
            return;
        end
        yv = ys[c];
        repeat (post_gap) @(negedge clk);
        ordy[c] = 1'b1;
        @(posedge clk);
        #1;
        ordy[c] = 1'b0;
    endtask

    typedef struct {
        int           c;
        logic [162:0] a;
        logic [162:0] b;
        logic [324:0] y;
    } vec_t;

    vec_t         vt [9];
    logic [324:0] yv;
    int           lat;
    int           saw_ov;

    initial begin
        checks = 0;
        fails  = 0;
        iv     = '0;
        ordy   = '0;
        av     = '0;
        bv     = '0;
        rst_n  = 1'b0;

        vt[0] = '{1, 163'hF, 163'hF, 325'h55};
        vt[1] = '{1, 163'h3, 163'h5, 325'hF};
        vt[2] = '{0, 163'h1, 163'h1, 325'h1};
        vt[3] = '{0, 163'(1) << 162, 163'(1) << 162, 325'(1) << 324};
        vt[4] = '{0, 163'(1) << 161, 163'h2, 325'(1) << 162};
        vt[5] = '{2, 163'h1F, 163'h1F, 325'h155};
        vt[6] = '{3, 163'hFFFF, 163'hFFFF, 325'h55555555};
        vt[7] = '{3, 163'h8001, 163'h8001, 325'h40000001};
        vt[8] = '{0, 163'h0, 163'h1234_5678, 325'h0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 325'(ov), 325'(0));
        chk("rst_in_ready", 325'(irdy), 325'(0));
        for (int c = 0; c < 4; c++) chk("rst_y", ys[c], 325'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", 325'(irdy), 325'hF);

        // Directed table
        for (int v = 0; v < 9; v++) begin
            xact(vt[v].c, vt[v].a, vt[v].b, 0, 0, yv, lat);
            chk($sformatf("vec%0d_y", v), yv, vt[v].y);
            chk($sformatf("vec%0d_lat", v), 325'(lat), 325'(exp_lat(vt[v].c)));
        end

        // Backpressure on the N=163 instance: (1+x)^2 = 1+x^2
        @(negedge clk);
        av[0] = 163'h3;
        bv[0] = 163'h3;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_lat", 325'(lat), 325'(34));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            iv[0] = 1'b1;
            av[0] = {163{1'b1}};
            bv[0] = {163{1'b1}};
            chk($sformatf("bp_hold%0d", k), {ys[0][322:0], irdy[0], ov[0]}, {323'h5, 1'b0, 1'b1});
        end
        @(negedge clk);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        chk("bp_release", {323'b0, irdy[0], ov[0]}, {323'b0, 1'b1, 1'b0});

        // Reset in the middle of MUL_O
        @(negedge clk);
        av[0] = 163'h7;
        bv[0] = 163'h5;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (13) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_async", {323'b0, irdy[0], ov[0]}, 325'(0));
        chk("midrst_y", ys[0], 325'(0));
        @(negedge clk);
        rst_n = 1'b1;
        saw_ov = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ov != 4'b0) saw_ov = 1;
        end
        chk("midrst_no_out_valid", 325'(saw_ov), 325'(0));
        chk("midrst_in_ready", 325'(irdy), 325'hF);

        // Random pairs against the software model
        for (int c = 0; c < 4; c++) begin
            if (c != 1) begin
                for (int n = 0; n < 1000; n++) begin
                    logic [162:0] ra, rb;
                    ra = rnd(c);
                    rb = rnd(c);
                    if (n == 0) ra = '0;
                    xact(c, ra, rb, $urandom_range(0, 2), $urandom_range(0, 2), yv, lat);
                    chk($sformatf("rand_c%0d_n%0d", c, n), yv, clmul(ra, rb));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
